// File: rtl/button_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_pkg : shared state encoding and 25 MHz timing defaults for     |
// |              the button press classifier.                           |
// | Revision   : 1.0                                                    |
// +----------------------------------------------------------------------+
package button_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  localparam int DEF_LONG_CYCLES   = 25000000;
  localparam int DEF_REPEAT_CYCLES = 6250000;
  localparam int DEF_CNT_W         = 25;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HELD = ST_HELD,
    S_LONG = ST_LONG
  } state_t;

endpackage
`default_nettype wire

// File: rtl/press_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | press_timer : CNT_W-bit hold counter with clear/enable and a runtime  |
// |               terminal value; terminal-count flag is registered.     |
// | Revision    : 1.0                                                   |
// +----------------------------------------------------------------------+
module press_timer
  import button_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Clear,
  input  logic             i_Enable,
  input  logic [CNT_W-1:0] i_Term,
  output logic             o_Tc
);

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic             r_tc;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + c_ONE;

  // The flag is precomputed one cycle ahead so it is high while the count
  // equals the terminal value; terminal values are always >= 1, so a clear
  // can safely drop it.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else if (i_Clear) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else if (i_Enable) begin
      r_cnt <= w_cnt_inc;
      r_tc  <= (w_cnt_inc == i_Term);
    end
  end

  assign o_Tc = r_tc;

endmodule
`default_nettype wire

// File: rtl/button_press_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_press_classifier : turns a debounced switch level into press, |
// |   release, short, long and (BUTTON_AUTOREPEAT_EN) auto-repeat pulses. |
// | Revision : 1.0                                                      |
// +----------------------------------------------------------------------+
module button_press_classifier
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Short,
  output logic o_Long,
  output logic o_Repeat,
  output logic o_Held
);

  state_t           r_state;
  state_t           w_next;
  logic             r_press, r_release, r_short, r_long, r_repeat;
  logic             w_press, w_release, w_short, w_long, w_repeat;
  logic             w_clr, w_en, w_tc;
  logic [CNT_W-1:0] w_term;

  assign w_term = (r_state == S_LONG) ? CNT_W'(REPEAT_CYCLES - 1)
                                      : CNT_W'(LONG_CYCLES - 1);

  press_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Clear  (w_clr),
    .i_Enable (w_en),
    .i_Term   (w_term),
    .o_Tc     (w_tc)
  );

  always_comb begin
    w_next    = r_state;
    w_press   = 1'b0;
    w_release = 1'b0;
    w_short   = 1'b0;
    w_long    = 1'b0;
    w_repeat  = 1'b0;
    w_clr     = 1'b0;
    w_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clr = 1'b1;
        if (i_Switch) begin
          w_next  = S_HELD;
          w_press = 1'b1;
        end
      end
      S_HELD: begin
        // Release outranks the long terminal count on the same edge.
        if (!i_Switch) begin
          w_next    = S_IDLE;
          w_release = 1'b1;
          w_short   = 1'b1;
          w_clr     = 1'b1;
        end else if (w_tc) begin
          w_next = S_LONG;
          w_long = 1'b1;
          w_clr  = 1'b1;
        end else begin
          w_en = 1'b1;
        end
      end
      S_LONG: begin
        if (!i_Switch) begin
          w_next    = S_IDLE;
          w_release = 1'b1;
          w_clr     = 1'b1;
        end else begin
`ifdef BUTTON_AUTOREPEAT_EN
          if (w_tc) begin
            w_repeat = 1'b1;
            w_clr    = 1'b1;
          end else begin
            w_en = 1'b1;
          end
`else
          w_clr = 1'b1;
`endif
        end
      end
      default: begin
        w_next = S_IDLE;
        w_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state   <= S_IDLE;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_press   <= w_press;
      r_release <= w_release;
      r_short   <= w_short;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
    end
  end

  assign o_Press   = r_press;
  assign o_Release = r_release;
  assign o_Short   = r_short;
  assign o_Long    = r_long;
  assign o_Repeat  = r_repeat;
  assign o_Held    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_button_press_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_button_press_classifier : directed + randomized self-checking     |
// |   bench with a press-duration reference model.                       |
// | Revision : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_button_press_classifier;

  localparam int L  = 8;
  localparam int R  = 4;
  localparam int CW = 4;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;
  logic o_Press, o_Release, o_Short, o_Long, o_Repeat, o_Held;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: press status and edges elapsed since the press edge.
  bit m_pressed = 1'b0;
  int m_k       = 0;
  bit e_press, e_rel, e_short, e_long, e_rep, e_held;

  always #5 clk = ~clk;

  button_press_classifier #(
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R),
    .CNT_W         (CW)
  ) dut (
    .i_Clk     (clk),
    .i_Reset   (rst),
    .i_Switch  (sw),
    .o_Press   (o_Press),
    .o_Release (o_Release),
    .o_Short   (o_Short),
    .o_Long    (o_Long),
    .o_Repeat  (o_Repeat),
    .o_Held    (o_Held)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".press"},   o_Press,   e_press);
    check({tag, ".release"}, o_Release, e_rel);
    check({tag, ".short"},   o_Short,   e_short);
    check({tag, ".long"},    o_Long,    e_long);
    check({tag, ".repeat"},  o_Repeat,  e_rep);
    check({tag, ".held"},    o_Held,    e_held);
  endtask

  task automatic model_edge(input logic s, input logic r);
    e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_rep = 0;
    if (r) begin
      m_pressed = 0;
      m_k       = 0;
    end else if (!m_pressed) begin
      if (s) begin
        m_pressed = 1;
        m_k       = 0;
        e_press   = 1;
      end
    end else begin
      m_k++;
      if (!s) begin
        m_pressed = 0;
        e_rel     = 1;
        e_short   = (m_k <= L);
      end else if (m_k == L) begin
        e_long = 1;
      end else if (AR && m_k > L && ((m_k - L) % R) == 0) begin
        e_rep = 1;
      end
    end
    e_held = m_pressed;
  endtask

  // Drive on the falling edge, check asynchronous reset immediately, then
  // check registered outputs 1 ns after the rising edge.
  task automatic cycle(input logic s, input logic r, input string tag);
    @(negedge clk);
    sw  = s;
    rst = r;
    if (r) begin
      #1;
      e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_rep = 0; e_held = 0;
      check_all({tag, ".async"});
    end
    @(posedge clk);
    model_edge(s, r);
    #1;
    check_all(tag);
  endtask

  task automatic hold(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, tag);
  endtask

  initial begin
    // 1: reset with switch high, press on the first edge after release
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, "t1_rst");
    hold(1, "t1_first");
    check("t1_press_fires", o_Press, 1'b1);
    idle(3, "t1_rel");
    // 2: 5-cycle press
    hold(5, "t2_hold");
    idle(3, "t2_rel");
    // 3: exactly LONG_CYCLES, release wins
    hold(L, "t3_hold");
    idle(1, "t3_rel");
    check("t3_short_boundary", o_Short, 1'b1);
    idle(2, "t3_idle");
    // 4: long hold with repeats
    hold(20, "t4_hold");
    idle(3, "t4_rel");
    // 5: reset mid long press, switch drops while in reset
    hold(10, "t5_hold");
    cycle(1'b1, 1'b1, "t5_rst");
    cycle(1'b0, 1'b1, "t5_rst");
    idle(3, "t5_after");
    hold(3, "t5_repress");
    idle(2, "t5_rel");
    // randomized episodes
    for (int ep = 0; ep < 60; ep++) begin
      int h, g;
      h = $urandom_range(1, 24);
      g = $urandom_range(1, 4);
      for (int i = 0; i < h; i++) begin
        if ($urandom_range(0, 99) == 0) cycle(1'b1, 1'b1, "rnd_rst");
        else cycle(1'b1, 1'b0, "rnd_hold");
      end
      for (int i = 0; i < g; i++) begin
        if ($urandom_range(0, 49) == 0) cycle($urandom_range(0, 1) == 1, 1'b1, "rnd_rst");
        else cycle(1'b0, 1'b0, "rnd_idle");
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
